// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the led_stretch LED pulse stretcher.
package led_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    // The counter must hold max(HOLD, GAP) - 1. The result is clamped to 1 bit so that HOLD = GAP = 1 still gives a legal width.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
        int unsigned m;
        m = (hold > gap) ? hold : gap;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// One stretcher channel: IDLE/ON/OFF FSM with a down-counter and a saturating pending flag.
// With LED_STRETCH_RETRIGGER_EN defined, a pulse during ON reloads the on-time instead of queueing a blink.
module led_stretch_ch
    import led_stretch_pkg::*;
#(
    parameter int unsigned HOLD = 5_000_000,
    parameter int unsigned GAP  = 2_500_000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic pulse,
    output logic led,
    output logic busy
);

    localparam int unsigned W = cnt_width(HOLD, GAP);
    localparam logic [W-1:0] HOLD_LOAD = W'(HOLD - 1);
    localparam logic [W-1:0] GAP_LOAD  = W'(GAP - 1);

    state_t         state;
    logic [W-1:0]   count;
    logic           pending;

    // led and busy are updated on the same transitions as state, so both stay registered copies of it.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= IDLE;
            count   <= '0;
            pending <= 1'b0;
            led     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pulse) begin
                        state <= ON;
                        count <= HOLD_LOAD;
                        led   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ON: begin
`ifdef LED_STRETCH_RETRIGGER_EN
                    if (pulse) begin
                        count <= HOLD_LOAD;
                    end else if (count != '0) begin
                        count <= count - W'(1);
                    end else begin
                        state <= OFF;
                        count <= GAP_LOAD;
                        led   <= 1'b0;
                    end
`else
                    if (pulse) begin
                        pending <= 1'b1;
                    end
                    if (count != '0) begin
                        count <= count - W'(1);
                    end else begin
                        state <= OFF;
                        count <= GAP_LOAD;
                        led   <= 1'b0;
                    end
`endif
                end
                OFF: begin
                    if (count != '0) begin
                        count <= count - W'(1);
                        if (pulse) begin
                            pending <= 1'b1;
                        end
                    end else if (pending || pulse) begin
                        state   <= ON;
                        count   <= HOLD_LOAD;
                        pending <= 1'b0;
                        led     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    count   <= '0;
                    pending <= 1'b0;
                    led     <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/led_stretch.sv
// Multi-channel LED pulse stretcher top: N independent channels plus a shared busy flag.
// Optional feature macro: LED_STRETCH_RETRIGGER_EN (handled inside led_stretch_ch).
module led_stretch #(
    parameter int unsigned N    = 8,
    parameter int unsigned HOLD = 5_000_000,
    parameter int unsigned GAP  = 2_500_000
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [N-1:0] pulse,
    output logic [N-1:0] led,
    output logic         busy
);

    logic [N-1:0] ch_busy;

    for (genvar i = 0; i < N; i++) begin : g_ch
        led_stretch_ch #(
            .HOLD(HOLD),
            .GAP (GAP)
        ) u_ch (
            .Clk    (Clk),
            .Reset_n(Reset_n),
            .pulse  (pulse[i]),
            .led    (led[i]),
            .busy   (ch_busy[i])
        );
    end

    // Each ch_busy is a flop, so this OR has no path back to pulse.
    always_comb busy = |ch_busy;

endmodule

// File: doc/led_stretch.md
# led_stretch

Multi-channel output pulse stretcher. It turns single-cycle internal events into human-visible LED blinks and is the output-side counterpart of the button/switch input synchronizers. It sits between the datapath or controller event strobes and the board LED pins. Each channel enforces a minimum on-time and a minimum off-time, so back-to-back events show as separate blinks.

## Interface
- N, default 8: number of independent channels.
- HOLD, default 5_000_000: LED on-time in Clk cycles (100 ms at 50 MHz). Must be ≥ 1.
- GAP, default 2_500_000: forced off-time after each blink, in Clk cycles. Must be ≥ 1.
- Clk  in  1  system clock; all state updates on the posedge.
- Reset_n  in  1  reset, synchronous, active-low.
- pulse  in  N  per-channel event strobes. Single-cycle or level; sampled every cycle. Already synchronous to Clk.
- led  out  N  per-channel stretched output, registered, drives pins directly.
- busy  out  1  registered OR of all channels not in IDLE.

## Operation
- Each channel is an independent FSM with a down-counter sized to $clog2(max(HOLD,GAP)) bits and a 1-bit pending flag.
- States:
  - IDLE: led 0.
  - ON: led 1; counter counts down from HOLD-1.
  - OFF: led 0; counter counts down from GAP-1.
- IDLE + pulse → ON, counter ← HOLD-1.
- ON:
  - counter ≠ 0 → decrement.
  - counter = 0 → OFF, counter ← GAP-1.
- OFF:
  - counter ≠ 0 → decrement.
  - counter = 0 and (pending or pulse) → ON, counter ← HOLD-1, pending ← 0.
  - otherwise → IDLE.
- pulse in ON (default build) or in OFF sets pending. Pending saturates at 1, so any number of pulses during one blink/gap produce exactly one extra blink.
- pulse on the final ON cycle sets pending. pulse on the final OFF cycle acts as pending.
- led[i] = (state == ON). busy = any state ≠ IDLE. Both are registered, with no combinational path from pulse.
- Reset (Reset_n low at a posedge): all channels go to IDLE; counter 0, pending 0, led 0, busy 0. Any blink in progress is truncated and pending events are discarded. Reset wins over a coincident pulse.

## Timing
- Latency: pulse high in cycle t while in IDLE → led high from cycle t+1.
- led stays high for exactly HOLD cycles, then low for at least GAP cycles.
- Minimum blink period is HOLD+GAP cycles.
- A pending event re-raises led in the cycle right after the last OFF cycle.
- Reset_n low in cycle t → led 0 from cycle t+1.
- Channels never interact. Simultaneous pulses on several channels give identical, aligned blinks.

## Configuration
- LED_STRETCH_RETRIGGER_EN:
  - Defined: pulse in ON reloads counter ← HOLD-1 and does not set pending. A continuous stream of events keeps the LED solid; it goes dark HOLD cycles after the last pulse. OFF behaviour is unchanged.
  - Undefined (default): pulse in ON sets pending as described in Operation.

## Structure
- Package led_stretch_pkg holds:
  - the state enum typedef (IDLE, ON, OFF);
  - a counter-width function computing $clog2 of max(HOLD, GAP).
- Sub-module led_stretch_ch is one channel (FSM, counter, pending) with HOLD/GAP parameters.
- The top level instantiates N copies with a generate loop and reduces busy.

## Test plan
All scenarios use N=4, HOLD=4, GAP=2.
- Single pulse on ch0 in cycle 10 → led[0] high cycles 11–14, low from 15; busy high 11–16; led[3:1] stay 0.
- Default build, ch0 pulses in cycles 10 and 12 → led[0] high 11–14, low 15–16, high 17–20.
- With LED_STRETCH_RETRIGGER_EN, ch0 pulses in cycles 10 and 12 → led[0] high 11–16, low from 17, no second blink.
- ch1 pulses in cycles 12, 13 and 16 (the last OFF cycle) after a pulse in cycle 10 → exactly one extra blink: led[1] high 17–20, then IDLE by cycle 23.
- ch2 pulse in cycle 10, Reset_n low in cycle 12 with a ch2 pulse also in cycle 12 → led[2] 0 from 13; no later blink.
- Pulses on ch0 and ch3 in cycle 10, ch1 pulse in cycle 11 → led[0] and led[3] high 11–14, led[1] high 12–15, independent.
